muldiv_unit: RTL

- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID-stage control unit.
- Accepts one M-extension operation plus two 32-bit operands, runs a multi-cycle state machine and returns a 32-bit result with a one-cycle done pulse.
- Busy drives the pipeline hazard logic to stall IF/ID/EX until done.

---
 rtl/muldiv_unit.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and 32-step restoring divide.
// Optional MULDIV_FAST_MUL_EN: multiplies complete in a single cycle; divides stay iterative.
module muldiv_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MUL_ITERS = WIDTH,
    parameter int unsigned DIV_ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OpMul    = 3'b000;
    localparam logic [2:0] OpMulh   = 3'b001;
    localparam logic [2:0] OpMulhsu = 3'b010;
    localparam logic [2:0] OpMulhu  = 3'b011;
    localparam logic [2:0] OpDiv    = 3'b100;
    localparam logic [2:0] OpDivu   = 3'b101;

    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1) {1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mag_q, mag_d;
    logic                 res_neg_q, res_neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;

    // Operand decode for the request presented this cycle
    logic                 a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 div_zero, div_ovf, special;
    logic [WIDTH-1:0]     special_res;

    always_comb begin
        a_signed    = op[2] ? ~op[0] : (op[1:0] != 2'b11);
        b_signed    = op[2] ? ~op[0] : ~op[1];
        a_neg       = a_signed & operand_a[WIDTH-1];
        b_neg       = b_signed & operand_b[WIDTH-1];
        a_mag       = a_neg ? -operand_a : operand_a;
        b_mag       = b_neg ? -operand_b : operand_b;
        div_zero    = (operand_b == '0);
        div_ovf     = op[2] & ~op[0] & (operand_a == MinNeg) & (operand_b == '1);
        special     = op[2] & (div_zero | div_ovf);
        special_res = op[1] ? (div_zero ? operand_a : '0) : (div_zero ? '1 : MinNeg);
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] a_ext, b_ext, fast_prod;

    // Sign/zero-extend to 64 bits; the low 64 bits of the product are exact either way
    always_comb begin
        a_ext     = a_signed ? {{WIDTH{operand_a[WIDTH-1]}}, operand_a}
                             : {{WIDTH{1'b0}}, operand_a};
        b_ext     = b_signed ? {{WIDTH{operand_b[WIDTH-1]}}, operand_b}
                             : {{WIDTH{1'b0}}, operand_b};
        fast_prod = a_ext * b_ext;
    end
`endif

    // One iteration of the datapath; acc holds {hi, multiplier} or {remainder, dividend/quotient}
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   step_next;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo, rem;
    logic [WIDTH-1:0]     final_res;
    logic                 last_iter;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mag_q});
        // The true difference is below the divisor, so truncating to WIDTH bits is exact
        div_rem   = div_ge ? (div_shift[WIDTH-1:0] - mag_q) : div_shift[WIDTH-1:0];
        div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};
        step_next = op_q[2] ? div_next : mul_next;

        prod = res_neg_q ? -step_next : step_next;
        quo  = step_next[WIDTH-1:0];
        rem  = step_next[2*WIDTH-1:WIDTH];

        case (op_q)
            OpMul:                      final_res = prod[WIDTH-1:0];
            OpMulh, OpMulhsu, OpMulhu:  final_res = prod[2*WIDTH-1:WIDTH];
            OpDiv, OpDivu:              final_res = res_neg_q ? -quo : quo;
            default:                    final_res = rem_neg_q ? -rem : rem;
        endcase

        last_iter = op_q[2] ? (cnt_q == CntW'(DIV_ITERS - 1))
                            : (cnt_q == CntW'(MUL_ITERS - 1));
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        mag_d     = mag_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        cnt_d     = cnt_q;
        result_d  = result_q;

        case (state_q)
            StIdle, StDone: begin
                if (start && !flush) begin
                    op_d      = op;
                    res_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    cnt_d     = '0;
                    if (op[2]) begin
                        acc_d = {{WIDTH{1'b0}}, a_mag};
                        mag_d = b_mag;
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, b_mag};
                        mag_d = a_mag;
                    end

                    if (special) begin
                        result_d = special_res;
                        state_d  = StDone;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!op[2]) begin
                        result_d = (op[1:0] == 2'b00) ? fast_prod[WIDTH-1:0]
                                                      : fast_prod[2*WIDTH-1:WIDTH];
                        state_d  = StDone;
                    end
`endif
                    else begin
                        state_d = StCalc;
                    end
                end else begin
                    state_d = StIdle;
                end
            end

            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d = step_next;
                    cnt_d = cnt_q + CntW'(1);
                    if (last_iter) begin
                        result_d = final_res;
                        state_d  = StDone;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= '0;
            acc_q     <= '0;
            mag_q     <= '0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            mag_q     <= mag_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    assign busy   = (state_q == StCalc);
    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule
